// File: rtl/instr_read_sequencer_if.sv
// instr_read_sequencer_if: instruction type plus the command/read-port/output bundle of the read sequencer
package instr_read_sequencer_pkg;
  typedef struct packed {
    logic [7:0] opc;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] result;
  } instruction_t;
endpackage

interface instr_read_sequencer_if #(parameter int ADDR_W = 5, parameter int CNT_W = 6);
  import instr_read_sequencer_pkg::*;
  logic start;
  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0] count;
  logic [ADDR_W-1:0] read_pointer;
  instruction_t instruction_word;
  logic out_valid;
  logic out_ready;
  instruction_t out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic busy;
  logic done;
  modport master(output start, start_addr, count, instruction_word, out_ready,
                 input read_pointer, out_valid, out_instr, out_addr, busy, done);
  modport slave(input start, start_addr, count, instruction_word, out_ready,
                output read_pointer, out_valid, out_instr, out_addr, busy, done);
endinterface

// File: rtl/instr_read_sequencer.sv
// instr_read_sequencer: walks read_pointer over a wrap-around range and hands each word out over valid/ready
module instr_read_sequencer
  import instr_read_sequencer_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic reset,
  instr_read_sequencer_if.slave bus
);
  typedef logic [ADDR_W-1:0] address_t;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t state;
  logic [CNT_W-1:0] remaining;
  address_t next_pointer;
  always_comb next_pointer = bus.read_pointer + address_t'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      remaining <= '0;
      bus.read_pointer <= '0;
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
      bus.out_addr <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (bus.count != '0) begin
            bus.read_pointer <= bus.start_addr;
            remaining <= bus.count;
            bus.busy <= 1'b1;
            state <= FETCH;
          end else bus.done <= 1'b1;
        end
        FETCH: begin
          bus.out_instr <= bus.instruction_word;
          bus.out_addr <= bus.read_pointer;
          bus.out_valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          remaining <= remaining - CNT_W'(1);
          // the burst exits on the last word, so remaining never underflows
          if (remaining == CNT_W'(1)) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state <= IDLE;
          end else begin
            bus.read_pointer <= next_pointer;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_read_sequencer.sv
// tb_instr_read_sequencer: directed bursts checked against a queue-based transaction model plus literal expectations
module tb_instr_read_sequencer;
  import instr_read_sequencer_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int hs = 0;
  instruction_t mem [32];
  typedef struct {
    logic [4:0] a;
    instruction_t d;
  } item_t;
  item_t q [$];
  bit live = 0;
  bit ebusy = 0;
  bit edone = 0;
  bit pv = 0;
  logic [4:0] p_addr;
  instruction_t p_instr;

  instr_read_sequencer_if #(.ADDR_W(5), .CNT_W(6)) bus ();
  instr_read_sequencer #(.ADDR_W(5), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  assign bus.instruction_word = mem[bus.read_pointer];

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [4:0] a, input logic [5:0] n);
    bus.start = 1'b1;
    bus.start_addr = a;
    bus.count = n;
    tick();
    bus.start = 1'b0;
  endtask

  // transaction model: a burst is the ordered list of locations it must deliver
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      ebusy = 0;
      edone = 0;
      pv = 0;
      live = 1;
    end else if (live) begin
      bit was_busy;
      chk("busy", 32'(bus.busy), 32'(ebusy));
      chk("done", 32'(bus.done), 32'(edone));
      if (bus.out_valid) begin
        if (q.size() == 0) chk("spurious_valid", 32'(bus.out_valid), 32'd0);
        else begin
          chk("out_addr", 32'(bus.out_addr), 32'(q[0].a));
          chk("out_instr", bus.out_instr, q[0].d);
        end
      end
      if (pv) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_addr", 32'(bus.out_addr), 32'(p_addr));
        chk("hold_instr", bus.out_instr, p_instr);
      end
      was_busy = ebusy;
      edone = 0;
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        void'(q.pop_front());
        hs++;
        if (q.size() == 0) begin
          edone = 1;
          ebusy = 0;
        end
      end else if (bus.start && !was_busy) begin
        if (bus.count == 0) edone = 1;
        else begin
          ebusy = 1;
          for (int i = 0; i < int'(bus.count); i++) begin
            item_t it;
            it.a = bus.start_addr + 5'(i);
            it.d = mem[it.a];
            q.push_back(it);
          end
        end
      end
      pv = bus.out_valid && !bus.out_ready;
      p_addr = bus.out_addr;
      p_instr = bus.out_instr;
    end
  end

  initial begin
    int h0;
    logic [4:0] wrap [4];
    wrap[0] = 5'd30; wrap[1] = 5'd31; wrap[2] = 5'd0; wrap[3] = 5'd1;
    for (int i = 0; i < 32; i++) mem[i] = instruction_t'(32'hA5000000 ^ (i * 32'h01030507));
    mem[0] = 32'h0A010203;
    mem[1] = 32'h1B040509;
    mem[2] = 32'h2C07080F;
    mem[5] = 32'h5E112233;
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.count = '0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      reset = 1'b1;
      bus.start = 1'($urandom);
      bus.start_addr = 5'($urandom);
      bus.count = 6'($urandom);
      bus.out_ready = 1'($urandom);
      tick();
    end
    reset = 1'b0;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rp", 32'(bus.read_pointer), 32'd0);
    chk("rst_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    tick();

    go(5'd0, 6'd3);
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) chk("basic_rp", 32'(bus.read_pointer), 32'd0);
      chk("basic_valid", 32'(bus.out_valid), 32'(c == 2 || c == 4 || c == 6));
      chk("basic_done", 32'(bus.done), 32'(c == 7));
      if (c == 2) chk("basic_w0", bus.out_instr, 32'h0A010203);
      if (c == 4) chk("basic_w1", bus.out_instr, 32'h1B040509);
      if (c == 6) chk("basic_w2", bus.out_instr, 32'h2C07080F);
      if (c == 2 || c == 4 || c == 6) chk("basic_addr", 32'(bus.out_addr), 32'(c / 2 - 1));
      tick();
    end

    bus.out_ready = 1'b0;
    go(5'd10, 6'd2);
    for (int c = 1; c <= 9; c++) begin
      bus.out_ready = (c >= 6);
      chk("bp_valid", 32'(bus.out_valid), 32'((c >= 2 && c <= 6) || c == 8));
      chk("bp_done", 32'(bus.done), 32'(c == 9));
      if (c >= 2 && c <= 6) begin
        chk("bp_addr", 32'(bus.out_addr), 32'd10);
        chk("bp_rp", 32'(bus.read_pointer), 32'd10);
      end
      if (c == 8) chk("bp_addr2", 32'(bus.out_addr), 32'd11);
      tick();
    end

    go(5'd30, 6'd4);
    for (int c = 1; c <= 9; c++) begin
      chk("wrap_valid", 32'(bus.out_valid), 32'(c % 2 == 0 && c <= 8));
      chk("wrap_done", 32'(bus.done), 32'(c == 9));
      if (c % 2 == 0 && c <= 8) chk("wrap_addr", 32'(bus.out_addr), 32'(wrap[c / 2 - 1]));
      tick();
    end
    chk("wrap_rp_idle", 32'(bus.read_pointer), 32'd1);

    go(5'd7, 6'd0);
    chk("zero_done", 32'(bus.done), 32'd1);
    chk("zero_busy", 32'(bus.busy), 32'd0);
    chk("zero_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("zero_done2", 32'(bus.done), 32'd0);
    chk("zero_valid2", 32'(bus.out_valid), 32'd0);

    h0 = hs;
    go(5'd0, 6'd3);
    for (int c = 1; c <= 10; c++) begin
      bus.start = (c == 3);
      bus.start_addr = 5'd20;
      bus.count = 6'd5;
      chk("ign_valid", 32'(bus.out_valid), 32'(c == 2 || c == 4 || c == 6));
      chk("ign_done", 32'(bus.done), 32'(c == 7));
      tick();
    end
    bus.start = 1'b0;
    chk("ign_words", 32'(hs - h0), 32'd3);

    go(5'd0, 6'd4);
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) bus.out_ready = 1'b0;
      tick();
    end
    chk("mid_valid_pre", 32'(bus.out_valid), 32'd1);
    chk("mid_addr_pre", 32'(bus.out_addr), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    chk("mid_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_done", 32'(bus.done), 32'd0);
    tick();
    chk("mid_done2", 32'(bus.done), 32'd0);
    go(5'd5, 6'd1);
    tick();
    chk("post_valid", 32'(bus.out_valid), 32'd1);
    chk("post_addr", 32'(bus.out_addr), 32'd5);
    chk("post_instr", bus.out_instr, 32'h5E112233);
    tick();
    chk("post_done", 32'(bus.done), 32'd1);
    chk("post_valid2", 32'(bus.out_valid), 32'd0);
    tick();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
